// File: rtl/counter_chain_sequencer.sv
// Run controller for the counter chain: clear, enable for a programmed window,
// settle one cycle, then capture the chain count and pulse done.
module counter_chain_sequencer #(
  parameter int COUNT_WIDTH  = 16,
  parameter int WINDOW_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  input  logic [COUNT_WIDTH-1:0]  chain_count,
  output logic                    chain_enable,
  output logic                    chain_clear,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [COUNT_WIDTH-1:0]  result,
  output logic [WINDOW_WIDTH-1:0] elapsed
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam logic [WINDOW_WIDTH-1:0] W_ONE = WINDOW_WIDTH'(1);

  logic [1:0]              state, state_nxt;
  logic [WINDOW_WIDTH-1:0] remain;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = ((remain != '0) && !abort) ? S_RUN : S_SETTLE;
      // remain is at least 1 in RUN, so it never wraps through zero
      S_RUN:    if ((remain == W_ONE) || abort) state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      remain       <= '0;
      chain_enable <= 1'b0;
      chain_clear  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      result       <= '0;
      elapsed      <= '0;
    end else begin
      state        <= state_nxt;
      chain_clear  <= (state_nxt == S_CLEAR);
      chain_enable <= (state_nxt == S_RUN);
      busy         <= (state_nxt != S_IDLE);
      done         <= (state == S_SETTLE);
      case (state)
        S_IDLE: if (start) begin
          remain  <= window_len;
          elapsed <= '0;
          aborted <= 1'b0;
        end
        S_CLEAR: aborted <= abort;
        S_RUN: begin
          remain  <= remain - W_ONE;
          elapsed <= elapsed + W_ONE;
          if (abort) aborted <= 1'b1;
        end
        S_SETTLE: result <= chain_count;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_chain_sequencer.sv
// Directed bench: a single 16-bit counter stands in for the chain.
module tb_counter_chain_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] window_len = '0;
  logic [15:0] chain_count;
  logic        chain_enable, chain_clear, busy, done, aborted;
  logic [15:0] result;
  logic [31:0] elapsed;

  int n_cmp = 0;
  int n_bad = 0;

  // run observations
  int          o_done_t, o_en, o_clr, o_done_cnt;
  logic [15:0] o_res, o_res_early;
  logic [31:0] o_el;
  logic        o_ab, o_busy0;

  counter_chain_sequencer #(.COUNT_WIDTH(16), .WINDOW_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .window_len(window_len), .chain_count(chain_count),
    .chain_enable(chain_enable), .chain_clear(chain_clear), .busy(busy),
    .done(done), .aborted(aborted), .result(result), .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            chain_count <= '0;
    else if (chain_clear)  chain_count <= '0;
    else if (chain_enable) chain_count <= chain_count + 16'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a run and record what happens; t=0 is the start-sampling edge.
  // abort_t/restart_t name the edge at which abort/start are sampled (-1 = never).
  task automatic run_collect(input logic [31:0] len, input int abort_t,
                             input int restart_t, input bit stop_at_done);
    int t;
    o_done_t = -1; o_en = 0; o_clr = 0; o_done_cnt = 0;
    o_res = '0; o_el = '0; o_ab = 1'b0; o_res_early = '0; o_busy0 = 1'b0;
    window_len = len;
    start = 1'b1;
    abort = (abort_t == 0);
    step();
    t = 0;
    o_busy0 = busy;
    while (t < 400) begin
      if (t == 1) o_res_early = result;
      if (chain_enable) o_en++;
      if (chain_clear) o_clr++;
      if (done) begin
        o_done_cnt++;
        if (o_done_t < 0) begin
          o_done_t = t; o_res = result; o_el = elapsed; o_ab = aborted;
        end
      end
      if (o_done_t >= 0 && (stop_at_done || t >= o_done_t + 3)) break;
      start = (t + 1 == restart_t);
      abort = (t + 1 == abort_t);
      step();
      t++;
    end
    start = 1'b0;
    abort = 1'b0;
    if (o_done_t < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: no done within 400 cycles (len=%0d)", len);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = i[0]; abort = ~i[0]; window_len = 32'd7;
      step();
      n_cmp++;
      if ({chain_enable, chain_clear, busy, done, aborted, result, elapsed} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got en=%b clr=%b busy=%b done=%b ab=%b res=%0d el=%0d, want all 0",
                 chain_enable, chain_clear, busy, done, aborted, result, elapsed);
      end
    end
    start = 1'b0; abort = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_normal();
    run_collect(32'd5, -1, -1, 1'b0);
    n_cmp++;
    if (o_clr !== 1 || o_en !== 5) begin
      n_bad++; $display("FAIL normal_pulses: clr=%0d en=%0d, want 1 5", o_clr, o_en);
    end
    n_cmp++;
    if (o_done_t !== 7 || o_done_cnt !== 1) begin
      n_bad++; $display("FAIL normal_latency: done_t=%0d cnt=%0d, want 7 1", o_done_t, o_done_cnt);
    end
    n_cmp++;
    if (o_res !== 16'd5 || o_el !== 32'd5 || o_ab !== 1'b0) begin
      n_bad++; $display("FAIL normal_result: res=%0d el=%0d ab=%b, want 5 5 0", o_res, o_el, o_ab);
    end
  endtask

  task automatic test_zero_window();
    run_collect(32'd0, -1, -1, 1'b0);
    n_cmp++;
    if (o_en !== 0 || o_done_t !== 2) begin
      n_bad++; $display("FAIL zero_timing: en=%0d done_t=%0d, want 0 2", o_en, o_done_t);
    end
    n_cmp++;
    if (o_res !== 16'd0 || o_el !== 32'd0 || o_ab !== 1'b0) begin
      n_bad++; $display("FAIL zero_result: res=%0d el=%0d ab=%b, want 0 0 0", o_res, o_el, o_ab);
    end
  endtask

  task automatic test_abort();
    // abort during the 3rd RUN cycle is sampled at edge k+4
    run_collect(32'd100, 4, -1, 1'b0);
    n_cmp++;
    if (o_en !== 3 || o_done_t !== 5) begin
      n_bad++; $display("FAIL abort_timing: en=%0d done_t=%0d, want 3 5", o_en, o_done_t);
    end
    n_cmp++;
    if (o_res !== 16'd3 || o_el !== 32'd3 || o_ab !== 1'b1) begin
      n_bad++; $display("FAIL abort_result: res=%0d el=%0d ab=%b, want 3 3 1", o_res, o_el, o_ab);
    end
    n_cmp++;
    if (aborted !== 1'b1 || result !== 16'd3) begin
      n_bad++; $display("FAIL abort_hold: ab=%b res=%0d, want 1 3", aborted, result);
    end
    run_collect(32'd4, -1, -1, 1'b0);
    n_cmp++;
    if (o_res !== 16'd4 || o_el !== 32'd4 || o_ab !== 1'b0) begin
      n_bad++; $display("FAIL after_abort: res=%0d el=%0d ab=%b, want 4 4 0", o_res, o_el, o_ab);
    end
    // abort while in CLEAR: no enable at all
    run_collect(32'd10, 1, -1, 1'b0);
    n_cmp++;
    if (o_en !== 0 || o_done_t !== 2 || o_el !== 32'd0 || o_ab !== 1'b1) begin
      n_bad++; $display("FAIL abort_in_clear: en=%0d done_t=%0d el=%0d ab=%b, want 0 2 0 1",
                        o_en, o_done_t, o_el, o_ab);
    end
    // abort together with start is an ordinary start
    run_collect(32'd3, 0, -1, 1'b0);
    n_cmp++;
    if (o_res !== 16'd3 || o_el !== 32'd3 || o_ab !== 1'b0 || o_done_t !== 5) begin
      n_bad++; $display("FAIL abort_with_start: res=%0d el=%0d ab=%b done_t=%0d, want 3 3 0 5",
                        o_res, o_el, o_ab, o_done_t);
    end
  endtask

  task automatic test_busy_reject();
    run_collect(32'd8, -1, 3, 1'b0);
    n_cmp++;
    if (o_done_cnt !== 1 || o_done_t !== 10 || o_el !== 32'd8 || o_en !== 8) begin
      n_bad++; $display("FAIL busy_reject: done_cnt=%0d done_t=%0d el=%0d en=%0d, want 1 10 8 8",
                        o_done_cnt, o_done_t, o_el, o_en);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_reject_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    run_collect(32'd8, -1, -1, 1'b1);
    n_cmp++;
    if (o_res !== 16'd8 || o_done_t !== 10) begin
      n_bad++; $display("FAIL b2b_first: res=%0d done_t=%0d, want 8 10", o_res, o_done_t);
    end
    // second start is driven during the done cycle
    run_collect(32'd2, -1, -1, 1'b0);
    n_cmp++;
    if (o_busy0 !== 1'b1 || o_res_early !== 16'd8) begin
      n_bad++; $display("FAIL b2b_start: busy=%b held_res=%0d, want 1 8", o_busy0, o_res_early);
    end
    n_cmp++;
    if (o_res !== 16'd2 || o_el !== 32'd2 || o_done_t !== 4) begin
      n_bad++; $display("FAIL b2b_second: res=%0d el=%0d done_t=%0d, want 2 2 4", o_res, o_el, o_done_t);
    end
  endtask

  task automatic test_reset_mid_run();
    int dn;
    window_len = 32'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_cmp++;
    if (chain_enable !== 1'b1) begin
      n_bad++; $display("FAIL mid_run_enabled: en=%b, want 1", chain_enable);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (chain_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: en=%b busy=%b done=%b, want 0 0 0", chain_enable, busy, done);
    end
    step();
    reset = 1'b1;
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) dn++;
    end
    n_cmp++;
    if (dn !== 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL lost_run: done_pulses=%0d busy=%b, want 0 0", dn, busy);
    end
    run_collect(32'd3, -1, -1, 1'b0);
    n_cmp++;
    if (o_res !== 16'd3 || o_el !== 32'd3 || o_done_t !== 5) begin
      n_bad++; $display("FAIL after_reset_run: res=%0d el=%0d done_t=%0d, want 3 3 5", o_res, o_el, o_done_t);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_window();
    test_abort();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
